// File: rtl/bcd_add_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential BCD adder.
// The sub line exists only when BCD_SUB_EN is defined.
`timescale 1ns/1ps
interface bcd_add_seq_if #(parameter int DIGITS = 4);
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  cin;
`ifdef BCD_SUB_EN
   logic                  sub;
`endif
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   sum;
   logic                  cout;
   logic                  err;
   logic [2:0]            phase;

   modport master (
`ifdef BCD_SUB_EN
      output sub,
`endif
      output start, a, b, cin,
      input  busy, done, sum, cout, err, phase
   );

   modport slave (
`ifdef BCD_SUB_EN
      input  sub,
`endif
      input  start, a, b, cin,
      output busy, done, sum, cout, err, phase
   );
endinterface

// File: rtl/bcd_add_seq.sv
// Sequential multi-digit BCD adder, one digit per SUM/CHECK/(CORR)/NEXT pass.
// Define BCD_SUB_EN to add ten's-complement subtraction via the sub input.
`timescale 1ns/1ps
module bcd_add_seq #(
   parameter int DIGITS = 4
) (
   input  logic           clk,
   input  logic           rst,
   bcd_add_seq_if.slave   bus
);
   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SUM   = 3'd1,
      CHECK = 3'd2,
      CORR  = 3'd3,
      NEXT  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_sum;
   logic [4:0]         r_tmp;
   logic               r_carry;
   logic               r_cout;
   logic               r_err;
   logic [IDX_W-1:0]   r_idx;

   logic [W-1:0]       w_b_lat;
   logic               w_cin_lat;
   logic [3:0]         w_a_dig;
   logic [3:0]         w_b_dig;
   logic [3:0]         w_corr;
   logic               w_last;
   logic               w_bad;

   function automatic logic bad_digit(input logic [W-1:0] v);
      logic f;
      f = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (v[i*4 +: 4] > 4'd9) f = 1'b1;
      return f;
   endfunction

`ifdef BCD_SUB_EN
   function automatic logic [W-1:0] nines(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++)
         r[i*4 +: 4] = 4'd9 - v[i*4 +: 4];
      return r;
   endfunction
`endif

   // Operand transform applied at accept; err always judges the raw b.
   always_comb begin
`ifdef BCD_SUB_EN
      w_b_lat   = bus.sub ? nines(bus.b) : bus.b;
      w_cin_lat = bus.sub ? 1'b1 : bus.cin;
`else
      w_b_lat   = bus.b;
      w_cin_lat = bus.cin;
`endif
      w_bad     = bad_digit(bus.a) | bad_digit(bus.b);
      w_a_dig   = r_a[int'(r_idx)*4 +: 4];
      w_b_dig   = r_b[int'(r_idx)*4 +: 4];
      w_corr    = r_tmp[3:0] + 4'd6;
      w_last    = (r_idx == IDX_W'(DIGITS - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = SUM;
         SUM:     w_next = CHECK;
         CHECK:   w_next = (r_tmp >= 5'd10) ? CORR : NEXT;
         CORR:    w_next = NEXT;
         NEXT:    w_next = w_last ? DONE : SUM;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_tmp   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a     <= bus.a;
                  r_b     <= w_b_lat;
                  r_carry <= w_cin_lat;
                  r_idx   <= '0;
                  r_sum   <= '0;
                  r_err   <= w_bad;
               end
            end
            SUM:   r_tmp <= {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'd0, r_carry};
            CHECK: begin
               if (r_tmp < 5'd10) begin
                  r_sum[int'(r_idx)*4 +: 4] <= r_tmp[3:0];
                  r_carry                   <= 1'b0;
               end
            end
            CORR: begin
               r_sum[int'(r_idx)*4 +: 4] <= w_corr;
               r_carry                   <= 1'b1;
            end
            // cout is captured on the way into DONE so it is valid with done.
            NEXT: begin
               if (w_last) r_cout <= r_carry;
               else        r_idx  <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy  = (r_state != IDLE);
   assign bus.done  = (r_state == DONE);
   assign bus.sum   = r_sum;
   assign bus.cout  = r_cout;
   assign bus.err   = r_err;
   assign bus.phase = r_state;
endmodule
